branch_ctrl: RTL
================

# branch_ctrl

Branch-resolution and flag-sequencing controller for the execute stage of the FIR processor pipeline. It owns the architectural NZCV flags register that feeds the condition-check unit and consumes that unit's CondEx and FlagsNext results. On a taken branch it issues a one-cycle PC redirect and squashes wrong-path instructions for a programmable number of cycles. It also keeps saturating taken/not-taken branch counters for profiling FIR loop behaviour.

## Interface
Parameters:
- FLUSH_CYCLES, 2: number of cycles the younger stages are squashed after a taken branch (1..7).
- CNT_W, 16: width of each branch statistics counter.

Ports:
- clk  in  1  pipeline clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- En  in  1  pipeline advance; 0 = global stall.
- BranchE  in  1  instruction in execute is a branch.
- CondExE  in  1  condition result from the condition-check unit.
- FlagsNextE  in  4  next-flags value from the condition-check unit, ordered {N,Z,C,V}.
- BranchTargetE  in  32  computed branch target.
- Flags  out  4  registered NZCV flags, fed back to the condition-check unit.
- PCSrc  out  1  one-cycle redirect strobe to fetch.
- BranchTarget  out  32  latched target; valid while PCSrc=1.
- FlushD  out  1  squash the decode-stage register.
- FlushE  out  1  squash the execute-stage register.
- Flushing  out  1  state is FLUSH.
- TakenCnt  out  CNT_W  saturating count of taken branches.
- NotTakenCnt  out  CNT_W  saturating count of not-taken branches.

## Operation
- States: IDLE, FLUSH.
- Live instruction: En=1 and state=IDLE. Only live instructions affect flags, counters or state.
- IDLE, live, BranchE=1, CondExE=1 (taken):
  - Register PCSrc=1 and latch BranchTarget.
  - Load the flush counter with FLUSH_CYCLES and go to FLUSH.
  - Increment TakenCnt.
- IDLE, live, BranchE=1, CondExE=0: increment NotTakenCnt. Nothing else changes.
- Flags register: Flags <= FlagsNextE on every live cycle. FlagsNextE already encodes FlagsWrite gating.
- FLUSH:
  - FlushD=FlushE=1 combinationally.
  - Counter decrements on each En=1 cycle. Return to IDLE when it reaches 0.
  - Flags, counters and BranchTarget hold. BranchE and FlagsNextE are ignored as wrong-path.
- En=0: state, counter, Flags and statistics counters freeze. PCSrc keeps its registered value until the next En=1 edge, so fetch sees the redirect when it advances.
- Statistics counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset values: Flags=0, PCSrc=0, BranchTarget=0, FlushD=FlushE=0, Flushing=0, state IDLE, flush counter 0, both statistics counters 0. Reset takes effect immediately, including mid-FLUSH.
- Taken branch live in execute at cycle t:
  - PCSrc=1 and FLUSH entered at cycle t+1.
  - PCSrc returns to 0 at t+2.
  - With En held high, FlushD/FlushE are high for cycles t+1 .. t+FLUSH_CYCLES, and the block is back in IDLE at t+FLUSH_CYCLES+1.
- Flag latency: FlagsNextE at cycle t appears on Flags at t+1, so a branch directly behind a flag-setter sees the updated flags.
- Simultaneous taken branch with a flag write: Flags updates and the redirect is issued in the same edge.
- Branch arriving on the cycle FLUSH exits: the block is still in FLUSH that cycle, so the branch is ignored.
- Stall during FLUSH: flush outputs stay high and the count is extended by the stall length.

## Structure
- Shared package cond_pkg holds:
  - State enum.
  - NZCV bit indices (N=3, Z=2, C=1, V=0).
  - Flags width constant.
  - FLUSH counter width (3).
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated twice for the statistics counters.

## Test plan
- Reset mid-FLUSH (FLUSH_CYCLES=2, rst pulsed at t+1) -> all outputs 0 in the same cycle; IDLE afterwards.
- Taken branch, En=1, BranchTargetE=0x0000_0040, FLUSH_CYCLES=2 -> PCSrc=1 and BranchTarget=0x40 at t+1 only; FlushD/FlushE high at t+1,t+2; TakenCnt=1.
- FlagsNextE=4'b0100 (Z) at t, then a branch at t+1 -> Flags=4'b0100 at t+1; branch at t+1 counted per its CondExE.
- Wrong-path branch with CondExE=1 and FlagsNextE=4'b1111 during FLUSH -> no new PCSrc; Flags unchanged; TakenCnt unchanged.
- En=0 for 3 cycles starting at t+1 after a taken branch -> PCSrc held high through the stall; flush lasts 5 cycles total.
- CNT_W=4, 17 not-taken branches -> NotTakenCnt=15 and holds; TakenCnt=0.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types and constants for the execute-stage branch/flag controller.
package cond_pkg;

    localparam int unsigned FLAGS_W   = 4;
    localparam int unsigned FLUSH_W   = 3;

    localparam int unsigned FLAG_N    = 3;
    localparam int unsigned FLAG_Z    = 2;
    localparam int unsigned FLAG_C    = 1;
    localparam int unsigned FLAG_V    = 0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage : cond_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/branch_ctrl.sv
// Execute-stage branch resolution: owns NZCV flags, issues PC redirects,
// squashes wrong-path instructions and keeps taken/not-taken statistics.
module branch_ctrl
    import cond_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               En,
    input  logic               BranchE,
    input  logic               CondExE,
    input  logic [FLAGS_W-1:0] FlagsNextE,
    input  logic [31:0]        BranchTargetE,
    output logic [FLAGS_W-1:0] Flags,
    output logic               PCSrc,
    output logic [31:0]        BranchTarget,
    output logic               FlushD,
    output logic               FlushE,
    output logic               Flushing,
    output logic [CNT_W-1:0]   TakenCnt,
    output logic [CNT_W-1:0]   NotTakenCnt
);

    state_t             r_state;
    logic [FLUSH_W-1:0] r_cnt;
    logic               r_pcsrc;
    logic [31:0]        r_target;
    logic [FLAGS_W-1:0] r_flags;

    state_t             w_state_nxt;
    logic [FLUSH_W-1:0] w_cnt_nxt;
    logic               w_pcsrc_nxt;
    logic [31:0]        w_target_nxt;
    logic [FLAGS_W-1:0] w_flags_nxt;
    logic               w_live;
    logic               w_taken;
    logic               w_not_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_pcsrc  <= 1'b0;
            r_target <= '0;
            r_flags  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pcsrc  <= w_pcsrc_nxt;
            r_target <= w_target_nxt;
            r_flags  <= w_flags_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pcsrc_nxt  = r_pcsrc;
        w_target_nxt = r_target;
        w_flags_nxt  = r_flags;
        w_live       = En && (r_state == ST_IDLE);
        w_taken      = w_live && BranchE && CondExE;
        w_not_taken  = w_live && BranchE && !CondExE;

        // PCSrc only advances with the pipeline so fetch cannot miss the redirect
        if (En) begin
            w_pcsrc_nxt = w_taken;
        end
        if (w_live) begin
            w_flags_nxt = FlagsNextE;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_taken) begin
                    w_target_nxt = BranchTargetE;
                    w_cnt_nxt    = FLUSH_W'(FLUSH_CYCLES);
                    w_state_nxt  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (En) begin
                    w_cnt_nxt = r_cnt - FLUSH_W'(1);
                    if (r_cnt == FLUSH_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign Flags        = r_flags;
    assign PCSrc        = r_pcsrc;
    assign BranchTarget = r_target;
    assign Flushing     = (r_state == ST_FLUSH);
    assign FlushD       = Flushing;
    assign FlushE       = Flushing;

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_taken),
        .count (TakenCnt)
    );

    sat_counter #(.W(CNT_W)) u_not_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_not_taken),
        .count (NotTakenCnt)
    );

endmodule : branch_ctrl
